conv_enc_k7: RTL and testbench

//  Rate-1/2 convolutional encoder with constraint length K. It is the transmit-side counterpart of
//  the Viterbi decoder's BMC/ACS/traceback chain. It takes a framed bit stream and emits one
//  2-bit coded pair per input bit. At frame end it appends K-1 zero tail bits, so the trellis

---
 rtl/viterbi_pkg.sv | 30 +++
 rtl/conv_enc_branch.sv | 13 +
 rtl/conv_enc_k7.sv | 104 ++++++++++
 tb/tb_conv_enc_k7.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared trellis parameters for the K=7 rate-1/2 code.
// Used by the encoder and the decoder's BMC/ACS blocks.
package viterbi_pkg;

  localparam int K   = 7;
  localparam int SW  = K - 1;
  localparam int TCW = $clog2(K);

  localparam logic [K-1:0] G0 = 7'o171;
  localparam logic [K-1:0] G1 = 7'o133;

  localparam logic [TCW-1:0] TAIL_END = TCW'(K - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENC,
    ST_TAIL
  } enc_state_e;

  // Expected pair {c1,c0} for a branch leaving state sr on input b
  function automatic logic [1:0] exp_pair(
    input logic [SW-1:0] sr,
    input logic          b
  );
    logic [K-1:0] r;
    r = {b, sr};
    return {^(r & G1), ^(r & G0)};
  endfunction

endpackage

// File: rtl/conv_enc_branch.sv
// Branch output of the K=7 trellis: (sr, bit) -> coded pair.
// Same definition the decoder's BMC uses per state.
module conv_enc_branch
  import viterbi_pkg::*;
(
  input  logic [SW-1:0] i_sr,
  input  logic          i_bit,
  output logic [1:0]    o_pair
);

  assign o_pair = exp_pair(i_sr, i_bit);

endmodule

// File: rtl/conv_enc_k7.sv
// Framed rate-1/2 K=7 convolutional encoder.
// Appends K-1 zero tail bits so each frame ends in state 0.
module conv_enc_k7
  import viterbi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_pair,
  output logic       out_last,
  output logic       busy
);

  enc_state_e     r_state;
  enc_state_e     w_state_nxt;
  logic [SW-1:0]  r_sr;
  logic [TCW-1:0] r_tail_cnt;
  logic           r_out_valid;
  logic [1:0]     r_out_pair;
  logic           r_out_last;

  logic           w_slot_free;
  logic           w_accept;
  logic           w_tail_step;
  logic           w_load;
  logic           w_bit;
  logic           w_tail_end;
  logic [1:0]     w_pair;

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_tail_step = (r_state == ST_TAIL) && w_slot_free;
  assign w_load      = w_accept || w_tail_step;
  assign w_bit       = (r_state == ST_TAIL) ? 1'b0 : in_bit;
  assign w_tail_end  = (r_tail_cnt == TAIL_END);

  conv_enc_branch u_branch (
    .i_sr   (r_sr),
    .i_bit  (w_bit),
    .o_pair (w_pair)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_ENC: begin
        if (w_accept)
          w_state_nxt = in_last ? ST_TAIL : ST_ENC;
      end
      ST_TAIL: begin
        if (w_slot_free && w_tail_end)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // in_ready is forced low while reset is being applied
  always_comb begin
    in_ready = 1'b0;
    busy     = (r_state != ST_IDLE) || r_out_valid;
    if (!rst && r_state != ST_TAIL)
      in_ready = w_slot_free;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr        <= '0;
      r_tail_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_pair  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_pair  <= w_pair;
        r_out_last  <= w_tail_step && w_tail_end;
        r_sr        <= {w_bit, r_sr[SW-1:1]};
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      if (w_accept && in_last)
        r_tail_cnt <= '0;
      else if (w_tail_step)
        r_tail_cnt <= r_tail_cnt + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_pair  = r_out_pair;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_conv_enc_k7.sv
// Bench for conv_enc_k7: cycle table plus handshake/reset sequences.
// Random frames are checked against a tap-level reference model.
module tb_conv_enc_k7;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_pair;
  logic       out_last;
  logic       busy;

  int total = 0;
  int bad   = 0;
  bit rnd_rdy = 0;

  logic [2:0] got_q[$];
  logic [2:0] exp_q[$];

  typedef struct {
    logic [3:0] in;
    logic [5:0] ex;
  } vec_t;

  vec_t tbl[17];

  conv_enc_k7 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pair  (out_pair),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor: samples just before each rising edge
  always @(negedge clk) begin
    #4;
    if (!rst && out_valid && out_ready)
      got_q.push_back({out_last, out_pair});
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk1(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, a, e);
    end
  endtask

  task automatic chk2(input string nm, input logic [1:0] a, input logic [1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, a, e);
    end
  endtask

  task automatic chk3(input string nm, input logic [2:0] a, input logic [2:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got={last,pair}=%b want=%b", nm, a, e);
    end
  endtask

  task automatic chki(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, a, e);
    end
  endtask

  // Taps written out from 171/133 octal, w[6] newest
  function automatic logic [1:0] mpar(input logic [6:0] w);
    logic c0, c1;
    c0 = w[6] ^ w[5] ^ w[4] ^ w[3] ^ w[0];
    c1 = w[6] ^ w[4] ^ w[3] ^ w[1] ^ w[0];
    return {c1, c0};
  endfunction

  task automatic model_frame(input logic [7:0] bits, input int len);
    logic [6:0] w;
    w = '0;
    for (int i = 0; i < len; i++) begin
      w = {bits[i], w[6:1]};
      exp_q.push_back({1'b0, mpar(w)});
    end
    for (int t = 0; t < 6; t++) begin
      w = {1'b0, w[6:1]};
      exp_q.push_back({t == 5, mpar(w)});
    end
  endtask

  // Called at a falling edge; returns at the falling edge after accept
  task automatic send(input logic b, input logic l);
    int n;
    bit done;
    n = 0;
    done = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = l;
    while (!done) begin
      #4;
      if (in_ready) done = 1;
      @(negedge clk);
      n++;
      if (!done && n > 200) begin
        chk1("send_timeout", 1'b0, 1'b1);
        done = 1;
      end
    end
  endtask

  task automatic wait_pairs(input int n);
    int c;
    c = 0;
    while (got_q.size() < n && c < 400) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic cmp_q(input string nm);
    int m;
    chki({nm, "_count"}, got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      chk3($sformatf("%s_pair%0d", nm, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] fb;
    int         fl;

    // in = {valid,bit,last,ready}, ex = {in_ready,out_valid,pair,last,busy}
    tbl[0]  = '{4'b1111, 6'b111101};
    tbl[1]  = '{4'b0001, 6'b010101};
    tbl[2]  = '{4'b0001, 6'b011101};
    tbl[3]  = '{4'b0001, 6'b011101};
    tbl[4]  = '{4'b0001, 6'b010001};
    tbl[5]  = '{4'b0001, 6'b011001};
    tbl[6]  = '{4'b0001, 6'b011111};
    tbl[7]  = '{4'b0001, 6'b100000};
    tbl[8]  = '{4'b1101, 6'b111101};
    tbl[9]  = '{4'b1011, 6'b110101};
    tbl[10] = '{4'b0001, 6'b011101};
    tbl[11] = '{4'b0001, 6'b011101};
    tbl[12] = '{4'b0001, 6'b010001};
    tbl[13] = '{4'b0001, 6'b011001};
    tbl[14] = '{4'b0001, 6'b011101};
    tbl[15] = '{4'b0001, 6'b010011};
    tbl[16] = '{4'b0001, 6'b100000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk2("rst_out_pair", out_pair, 2'b00);
    chk1("rst_out_last", out_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // Impulse frame then two-bit frame, cycle by cycle
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      {in_valid, in_bit, in_last, out_ready} = tbl[i].in;
      #1;
      chk1($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].ex[5]);
      @(posedge clk);
      #1;
      chk1($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ex[4]);
      if (tbl[i].ex[4]) begin
        chk2($sformatf("tbl%0d_pair", i), out_pair, tbl[i].ex[3:2]);
        chk1($sformatf("tbl%0d_last", i), out_last, tbl[i].ex[1]);
      end
      chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].ex[0]);
    end

    // Backpressure: first pair held for 5 clocks, stray input refused
    @(negedge clk);
    in_valid = 1'b0;
    got_q.delete();
    exp_q.delete();
    model_frame(8'h01, 1);
    send(1'b1, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bit    = 1'b0;
    in_last   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1($sformatf("bp%0d_valid", i), out_valid, 1'b1);
      chk2($sformatf("bp%0d_pair", i), out_pair, 2'b11);
      chk1($sformatf("bp%0d_in_ready", i), in_ready, 1'b0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_pairs(7);
    cmp_q("bp");
    chk1("bp_busy_after", busy, 1'b0);

    // Back-to-back frames of 3 random bits
    for (int f = 0; f < 2; f++) begin
      fb = 8'($urandom_range(0, 7));
      model_frame(fb, 3);
      for (int i = 0; i < 3; i++) send(fb[i], i == 2);
    end
    in_valid = 1'b0;
    wait_pairs(18);
    cmp_q("b2b");

    // Reset while the third tail pair would load
    send(1'b1, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("rstmid_in_ready", in_ready, 1'b0);
    @(negedge clk);
    #1;
    chk1("rstmid_out_valid", out_valid, 1'b0);
    chk1("rstmid_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    got_q.delete();
    exp_q.delete();
    model_frame(8'h01, 1);
    send(1'b1, 1'b1);
    in_valid = 1'b0;
    wait_pairs(7);
    if (got_q.size() > 0) chk3("rstmid_first", got_q[0], 3'b011);
    else chk1("rstmid_first_missing", 1'b0, 1'b1);
    cmp_q("rstmid");

    // Random frames with random out_ready
    rnd_rdy = 1;
    for (int f = 0; f < 6; f++) begin
      fl = $urandom_range(1, 8);
      fb = 8'($urandom);
      model_frame(fb, fl);
      for (int i = 0; i < fl; i++) send(fb[i], i == fl - 1);
    end
    in_valid = 1'b0;
    wait_pairs(exp_q.size());
    rnd_rdy = 0;
    @(negedge clk);
    out_ready = 1'b1;
    cmp_q("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
